uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser_if.sv | 44 ++++
 rtl/uart_cmd_parser.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser_if
// Groups the byte stream from uart_rx, the request/ack handshake towards the
// SDRAM controller, and the status/error outputs of uart_cmd_parser.
//
// Signals:
//   rx_data   [7:0]            received byte, valid while po_flag = 1
//   po_flag                    one-cycle byte-valid strobe
//   wr_req / rd_req            write / read request, held until req_ack
//   cmd_addr  [ADDR_WIDTH-1:0] request address
//   wr_data   [DATA_WIDTH-1:0] write data
//   req_ack                    controller acceptance of the pending request
//   busy                       parser is inside a frame or a request
//   err_flag / err_code [1:0]  one-cycle error pulse and its cause
//
// Modports:
//   master : the parser (consumes bytes and acks, drives requests/status)
//   slave  : the surrounding logic (uart_rx + SDRAM controller side)
// ---------------------------------------------------------------------------
interface uart_cmd_parser_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  po_flag;
  logic                  wr_req;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  req_ack;
  logic                  busy;
  logic                  err_flag;
  logic [1:0]            err_code;

  modport master (
    input  rx_data, po_flag, req_ack,
    output wr_req, rd_req, cmd_addr, wr_data, busy, err_flag, err_code
  );

  modport slave (
    output rx_data, po_flag, req_ack,
    input  wr_req, rd_req, cmd_addr, wr_data, busy, err_flag, err_code
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
// Collects UART bytes into command frames
//   HEADER, CMD, A2, A1, A0 [, D1, D0 for writes] [, CSUM]
// and issues one write or read request per frame to the SDRAM controller
// using a req/ack handshake. An inter-byte timeout aborts stalled frames.
//
// Ports:
//   sys_clk  system clock (same domain as uart_rx)
//   sys_rst  asynchronous, active-high reset
//   bus      uart_cmd_parser_if.master: rx_data/po_flag in, req_ack in,
//            wr_req/rd_req/cmd_addr/wr_data out, busy, err_flag/err_code out
//
// err_code: 1 = bad command, 2 = inter-byte timeout, 3 = overrun/checksum.
//
// Optional feature: define UART_CMD_CSUM_EN to require a trailing checksum
// byte (XOR of CMD, address and data bytes, HEADER excluded).
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter int         ADDR_WIDTH  = 24,
  parameter int         DATA_WIDTH  = 16,
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         TIMEOUT_CYC = 200_000
) (
  input logic               sys_clk,
  input logic               sys_rst,
  uart_cmd_parser_if.master bus
);

  localparam logic [7:0] OP_WRITE = 8'hA0;
  localparam logic [7:0] OP_READ  = 8'hA1;

  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam int              TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
`ifdef UART_CMD_CSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
`endif

  logic [2:0]            state_reg,    state_next;
  logic                  op_write_reg, op_write_next;
  logic [1:0]            cnt_reg,      cnt_next;
  logic [TW-1:0]         timer_reg,    timer_next;
  logic [ADDR_WIDTH-1:0] addr_reg,     addr_next;
  logic [DATA_WIDTH-1:0] data_reg,     data_next;
  logic                  wr_req_reg,   wr_req_next;
  logic                  rd_req_reg,   rd_req_next;
  logic                  err_flag_reg, err_flag_next;
  logic [1:0]            err_code_reg, err_code_next;
`ifdef UART_CMD_CSUM_EN
  logic [7:0]            csum_reg,     csum_next;
`endif

  // States in which the inter-byte timer runs.
  logic in_frame;
`ifdef UART_CMD_CSUM_EN
  assign in_frame = (state_reg == S_CMD) || (state_reg == S_ADDR) ||
                    (state_reg == S_DATA) || (state_reg == S_CSUM);
`else
  assign in_frame = (state_reg == S_CMD) || (state_reg == S_ADDR) ||
                    (state_reg == S_DATA);
`endif

  always_comb begin
    state_next    = state_reg;
    op_write_next = op_write_reg;
    cnt_next      = cnt_reg;
    timer_next    = timer_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    wr_req_next   = wr_req_reg;
    rd_req_next   = rd_req_reg;
    err_flag_next = 1'b0;
    err_code_next = err_code_reg;
`ifdef UART_CMD_CSUM_EN
    csum_next     = csum_reg;
`endif

    // Inter-byte timeout. A byte in the terminal-count cycle wins, so the
    // expiry branch is only taken when no byte is present.
    if (bus.po_flag || !in_frame) begin
      timer_next = '0;
    end else if (timer_reg == TIMER_LAST) begin
      timer_next    = '0;
      state_next    = S_IDLE;
      addr_next     = '0;
      data_next     = '0;
      err_flag_next = 1'b1;
      err_code_next = ERR_TIMEOUT;
    end else begin
      timer_next = timer_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        // Non-header bytes are discarded silently.
        if (bus.po_flag && (bus.rx_data == HEADER)) begin
          state_next = S_CMD;
          addr_next  = '0;
          data_next  = '0;
        end
      end

      S_CMD: begin
        if (bus.po_flag) begin
          if ((bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ)) begin
            op_write_next = (bus.rx_data == OP_WRITE);
            cnt_next      = '0;
            state_next    = S_ADDR;
`ifdef UART_CMD_CSUM_EN
            csum_next     = bus.rx_data;
`endif
          end else begin
            state_next    = S_IDLE;
            err_flag_next = 1'b1;
            err_code_next = ERR_CMD;
          end
        end
      end

      S_ADDR: begin
        if (bus.po_flag) begin
          addr_next = {addr_reg[ADDR_WIDTH-9:0], bus.rx_data};
`ifdef UART_CMD_CSUM_EN
          csum_next = csum_reg ^ bus.rx_data;
`endif
          if (cnt_reg == 2'd2) begin
            cnt_next = '0;
            if (op_write_reg) begin
              state_next = S_DATA;
            end else begin
`ifdef UART_CMD_CSUM_EN
              state_next  = S_CSUM;
`else
              state_next  = S_ISSUE;
              rd_req_next = 1'b1;
`endif
            end
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end

      S_DATA: begin
        if (bus.po_flag) begin
          data_next = {data_reg[DATA_WIDTH-9:0], bus.rx_data};
`ifdef UART_CMD_CSUM_EN
          csum_next = csum_reg ^ bus.rx_data;
`endif
          if (cnt_reg == 2'd1) begin
            cnt_next = '0;
`ifdef UART_CMD_CSUM_EN
            state_next  = S_CSUM;
`else
            state_next  = S_ISSUE;
            wr_req_next = 1'b1;
`endif
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end

`ifdef UART_CMD_CSUM_EN
      S_CSUM: begin
        if (bus.po_flag) begin
          if (bus.rx_data == csum_reg) begin
            state_next  = S_ISSUE;
            wr_req_next = op_write_reg;
            rd_req_next = !op_write_reg;
          end else begin
            state_next    = S_IDLE;
            err_flag_next = 1'b1;
            err_code_next = ERR_OVERRUN;
          end
        end
      end
`endif

      S_ISSUE: begin
        // The ack completes independently of a stray byte; the byte itself
        // is always dropped and flagged.
        if (bus.req_ack) begin
          wr_req_next = 1'b0;
          rd_req_next = 1'b0;
          state_next  = S_IDLE;
        end
        if (bus.po_flag) begin
          err_flag_next = 1'b1;
          err_code_next = ERR_OVERRUN;
        end
      end

      default: begin
        state_next  = S_IDLE;
        wr_req_next = 1'b0;
        rd_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= S_IDLE;
      op_write_reg <= 1'b0;
      cnt_reg      <= '0;
      timer_reg    <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      wr_req_reg   <= 1'b0;
      rd_req_reg   <= 1'b0;
      err_flag_reg <= 1'b0;
      err_code_reg <= '0;
`ifdef UART_CMD_CSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      op_write_reg <= op_write_next;
      cnt_reg      <= cnt_next;
      timer_reg    <= timer_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      wr_req_reg   <= wr_req_next;
      rd_req_reg   <= rd_req_next;
      err_flag_reg <= err_flag_next;
      err_code_reg <= err_code_next;
`ifdef UART_CMD_CSUM_EN
      csum_reg     <= csum_next;
`endif
    end
  end

  assign bus.wr_req   = wr_req_reg;
  assign bus.rd_req   = rd_req_reg;
  assign bus.cmd_addr = addr_reg;
  assign bus.wr_data  = data_reg;
  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.err_flag = err_flag_reg;
  assign bus.err_code = err_code_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed bench for uart_cmd_parser: a table of complete/erroneous frames
// followed by hand-written sequences for timeout, terminal-count race,
// overrun, simultaneous ack+byte, asynchronous reset and (when
// UART_CMD_CSUM_EN is defined) checksum mismatch.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;
  localparam int T = 20;  // short timeout keeps the run small

`ifdef UART_CMD_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  uart_cmd_parser_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) bus_if ();

  uart_cmd_parser #(
    .ADDR_WIDTH (24),
    .DATA_WIDTH (16),
    .HEADER     (8'h55),
    .TIMEOUT_CYC(T)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus_if.master)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // frame holds n bytes right-aligned, first byte most significant.
  typedef struct {
    logic [79:0] frame;
    int          n;
    logic [7:0]  csum;
    logic        exp_wr;
    logic        exp_rd;
    logic [23:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following posedge and
  // the task returns at the negedge after it.
  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data = b;
    bus_if.po_flag = 1'b1;
    @(negedge sys_clk);
    bus_if.po_flag = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] f, input int n,
                            input logic [7:0] cs, input bit with_csum);
    int total;
    total = n + ((CSUM_EN && with_csum) ? 1 : 0);
    for (int i = 0; i < total; i++) begin
      if (i < n) send_byte(f[8*(n-1-i) +: 8]);
      else       send_byte(cs);
      if (i < total - 1) chk("err_mid", 32'(bus_if.err_flag), 32'd0);
    end
  endtask

  task automatic do_ack(input string tag);
    bus_if.req_ack = 1'b1;
    @(negedge sys_clk);
    bus_if.req_ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus_if.wr_req | bus_if.rd_req), 32'd0);
    chk({tag, "_busy_drop"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;

    bus_if.rx_data = 8'h00;
    bus_if.po_flag = 1'b0;
    bus_if.req_ack = 1'b0;

    //            frame                  n  csum   wr    rd    addr        data      err   code
    vecs[0] = '{80'h0013_55A7,           4, 8'h00, 1'b0, 1'b0, 24'h000000, 16'h0000, 1'b1, 2'd1};
    vecs[1] = '{80'h55A0_0123_45BE_EF,   7, 8'h96, 1'b1, 1'b0, 24'h012345, 16'hBEEF, 1'b0, 2'd0};
    vecs[2] = '{80'h55A1_7FFF_FE,        5, 8'hDF, 1'b0, 1'b1, 24'h7FFFFE, 16'h0000, 1'b0, 2'd0};
    vecs[3] = '{80'h1255_A0FF_0080_0001, 8, 8'hDE, 1'b1, 1'b0, 24'hFF0080, 16'h0001, 1'b0, 2'd0};
    vecs[4] = '{80'h55A1_C35A_96,        5, 8'hAE, 1'b0, 1'b1, 24'hC35A96, 16'h0000, 1'b0, 2'd0};

    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_wr_req",   32'(bus_if.wr_req),   32'd0);
    chk("rst_rd_req",   32'(bus_if.rd_req),   32'd0);
    chk("rst_busy",     32'(bus_if.busy),     32'd0);
    chk("rst_err_flag", 32'(bus_if.err_flag), 32'd0);
    chk("rst_err_code", 32'(bus_if.err_code), 32'd0);
    chk("rst_cmd_addr", 32'(bus_if.cmd_addr), 32'd0);
    chk("rst_wr_data",  32'(bus_if.wr_data),  32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].frame, vecs[v].n, vecs[v].csum, vecs[v].exp_wr | vecs[v].exp_rd);
      $display("frame %0d: wr_req=%0b rd_req=%0b cmd_addr=%06h wr_data=%04h err_flag=%0b err_code=%0d",
               v, bus_if.wr_req, bus_if.rd_req, bus_if.cmd_addr, bus_if.wr_data,
               bus_if.err_flag, bus_if.err_code);
      chk("wr_req",   32'(bus_if.wr_req),   32'(vecs[v].exp_wr));
      chk("rd_req",   32'(bus_if.rd_req),   32'(vecs[v].exp_rd));
      chk("err_flag", 32'(bus_if.err_flag), 32'(vecs[v].exp_err));
      chk("busy",     32'(bus_if.busy),     32'(vecs[v].exp_wr | vecs[v].exp_rd));
      if (vecs[v].exp_err) begin
        chk("err_code", 32'(bus_if.err_code), 32'(vecs[v].exp_code));
        @(negedge sys_clk);
        chk("err_pulse_width", 32'(bus_if.err_flag), 32'd0);
      end
      if (vecs[v].exp_wr | vecs[v].exp_rd) begin
        chk("cmd_addr", 32'(bus_if.cmd_addr), 32'(vecs[v].exp_addr));
        if (vecs[v].exp_wr) chk("wr_data", 32'(bus_if.wr_data), 32'(vecs[v].exp_data));
        repeat (5) @(negedge sys_clk);
        chk("hold_wr_req", 32'(bus_if.wr_req), 32'(vecs[v].exp_wr));
        chk("hold_rd_req", 32'(bus_if.rd_req), 32'(vecs[v].exp_rd));
        chk("hold_addr",   32'(bus_if.cmd_addr), 32'(vecs[v].exp_addr));
        do_ack("vec");
      end
    end

    // Inter-byte timeout: 55 A0 01 then silence
    send_frame(80'h55A001, 3, 8'h00, 1'b0);
    chk("to_busy_before", 32'(bus_if.busy), 32'd1);
    wait_cyc = 0;
    while (wait_cyc < T + 10 && !bus_if.err_flag) begin
      @(negedge sys_clk);
      wait_cyc++;
    end
    $display("timeout: err_flag after %0d idle cycles, err_code=%0d", wait_cyc, bus_if.err_code);
    chk("to_latency",  32'(wait_cyc),          32'(T));
    chk("to_err_code", 32'(bus_if.err_code),   32'd2);
    chk("to_busy",     32'(bus_if.busy),       32'd0);
    chk("to_cleared",  32'(bus_if.cmd_addr),   32'd0);
    send_frame(80'h55A1_7FFF_FE, 5, 8'hDF, 1'b1);
    $display("after timeout: rd_req=%0b cmd_addr=%06h", bus_if.rd_req, bus_if.cmd_addr);
    chk("to_next_rd_req", 32'(bus_if.rd_req),   32'd1);
    chk("to_next_addr",   32'(bus_if.cmd_addr), 32'h7FFFFE);
    do_ack("to_next");

    // Byte arriving exactly at the timeout terminal count wins
    send_frame(80'h55A001, 3, 8'h00, 1'b0);
    repeat (T - 1) @(negedge sys_clk);
    send_frame(80'h2345BEEF, 4, 8'h96, 1'b1);
    $display("terminal-count race: wr_req=%0b cmd_addr=%06h wr_data=%04h",
             bus_if.wr_req, bus_if.cmd_addr, bus_if.wr_data);
    chk("tc_wr_req",  32'(bus_if.wr_req),  32'd1);
    chk("tc_addr",    32'(bus_if.cmd_addr), 32'h012345);
    chk("tc_data",    32'(bus_if.wr_data),  32'hBEEF);
    do_ack("tc");

    // Overrun in ISSUE, then ack and byte in the same cycle
    send_frame(80'h55A0_0123_45BE_EF, 7, 8'h96, 1'b1);
    chk("ov_wr_req", 32'(bus_if.wr_req), 32'd1);
    send_byte(8'h33);
    $display("overrun: err_flag=%0b err_code=%0d wr_req=%0b", bus_if.err_flag, bus_if.err_code, bus_if.wr_req);
    chk("ov_err_flag", 32'(bus_if.err_flag), 32'd1);
    chk("ov_err_code", 32'(bus_if.err_code), 32'd3);
    chk("ov_wr_hold",  32'(bus_if.wr_req),   32'd1);
    chk("ov_addr",     32'(bus_if.cmd_addr), 32'h012345);
    @(negedge sys_clk);
    chk("ov_err_clear", 32'(bus_if.err_flag), 32'd0);
    bus_if.req_ack = 1'b1;
    bus_if.rx_data = 8'h44;
    bus_if.po_flag = 1'b1;
    @(negedge sys_clk);
    bus_if.req_ack = 1'b0;
    bus_if.po_flag = 1'b0;
    $display("ack+byte: wr_req=%0b busy=%0b err_flag=%0b", bus_if.wr_req, bus_if.busy, bus_if.err_flag);
    chk("ab_wr_req",   32'(bus_if.wr_req),   32'd0);
    chk("ab_busy",     32'(bus_if.busy),     32'd0);
    chk("ab_err_flag", 32'(bus_if.err_flag), 32'd1);
    chk("ab_err_code", 32'(bus_if.err_code), 32'd3);

    // Asynchronous reset mid-frame
    send_frame(80'h55A00123, 4, 8'h00, 1'b0);
    chk("ar_busy_before", 32'(bus_if.busy), 32'd1);
    #3 sys_rst = 1'b1;
    #1;
    $display("async reset: busy=%0b cmd_addr=%06h err_code=%0d", bus_if.busy, bus_if.cmd_addr, bus_if.err_code);
    chk("ar_busy",     32'(bus_if.busy),     32'd0);
    chk("ar_cmd_addr", 32'(bus_if.cmd_addr), 32'd0);
    chk("ar_err_code", 32'(bus_if.err_code), 32'd0);
    chk("ar_reqs",     32'(bus_if.wr_req | bus_if.rd_req), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

`ifdef UART_CMD_CSUM_EN
    // Checksum mismatch: correct value would be B1
    send_frame(80'h55A1_0000_10, 5, 8'h00, 1'b1);
    $display("csum mismatch: err_flag=%0b err_code=%0d rd_req=%0b", bus_if.err_flag, bus_if.err_code, bus_if.rd_req);
    chk("cs_err_flag", 32'(bus_if.err_flag), 32'd1);
    chk("cs_err_code", 32'(bus_if.err_code), 32'd3);
    chk("cs_rd_req",   32'(bus_if.rd_req),   32'd0);
    chk("cs_busy",     32'(bus_if.busy),     32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
